d_cache_nway_control: RTL and testbench
=======================================

Name: d_cache_nway_control

Overview:
- Parametrised N-way, write-back, write-allocate data-cache controller for the LC-3b memory hierarchy, between CPU memory port and physical memory.
- Drives way-indexed datapath controls: data/dirty/valid writes, victim select, LRU update, line buffer load.
- Adds invalid-way victim preference and a full-cache flush engine that walks every set and way, writing back dirty lines.

Parameters:
- WAYS, 4, associativity; power of 2, at least 2; WAY_W = $clog2(WAYS) is derived.
- SETS, 8, number of sets; power of 2; SET_W = $clog2(SETS) is derived.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- mem_read / mem_write  in  1  CPU request; held until mem_resp.
- mem_resp  out  1  CPU request complete.
- hit_vec  in  WAYS  per-way tag compare for the current index.
- valid_vec / dirty_vec  in  WAYS  per-way valid/dirty bits at the current index.
- lru_way  in  WAY_W  LRU way of the current set, from the datapath.
- way_sel  out  WAY_W  way feeding the output/writeback mux.
- data_write  out  WAYS  one-hot line data write strobe.
- dirty_write  out  WAYS  one-hot dirty-bit write strobe.
- dirty_val  out  1  value written to the dirty bit.
- valid_write  out  WAYS  one-hot valid set, on fill.
- lru_update  out  1  LRU array update strobe.
- mru_way  out  WAY_W  way just accessed.
- load_buf  out  1  load fill buffer from pmem.
- wb_addr_sel  out  1  pmem address comes from the victim tag, not the CPU tag.
- flush_req  in  1  start a full-cache flush.
- flush_active  out  1  index comes from flush_set.
- flush_set  out  SET_W  flush index.
- flush_done  out  1  one-cycle pulse at flush completion.
- pmem_resp  in  1  physical memory done.
- pmem_read / pmem_write  out  1  physical memory request.
- clr_cnt  in  1  clear performance counters.
- hit_cnt / miss_cnt / wb_cnt  out  CNT_W  performance counters.

Behaviour:
- While rst is high: all outputs 0; state CHECK; victim, flush_set and flush_way cleared. Reset mid-transaction aborts immediately; pmem_read and pmem_write drop in the same cycle.
- Hit = |(hit_vec & valid_vec). Hit way is the lowest set index in that vector.
- States: CHECK, WB, FILL, RESPOND, FL_SCAN, FL_WB.
- CHECK, request and hit (zero-wait, combinational):
  - mem_resp=1, lru_update=1, mru_way=hit way, way_sel=hit way.
  - On write also: data_write, dirty_write one-hot at the hit way; dirty_val=1.
  - Stay in CHECK.
- CHECK, request and miss:
  - Victim register = lowest-index invalid way if any, else lru_way.
  - Next state WB if the chosen way is valid and dirty, else FILL.
- WB:
  - pmem_write=1, wb_addr_sel=1, way_sel=victim.
  - On pmem_resp: dirty_write[victim]=1, dirty_val=0, go to FILL.
- FILL:
  - pmem_read=1, load_buf=1.
  - On pmem_resp: data_write[victim]=1, valid_write[victim]=1, go to RESPOND.
- RESPOND: same actions as a hit, using the victim way; then CHECK.
- Miss latency = 2 + pmem cycles (fill) or 2 + both transfers (writeback plus fill).
- CHECK, flush_req and no CPU request: go to FL_SCAN with flush_set=0, flush_way=0. A CPU request in the same cycle wins; flush_req must be held.
- FL_SCAN:
  - flush_active=1, way_sel=flush_way.
  - If valid_vec and dirty_vec at flush_way are both set, go to FL_WB; else advance.
- FL_WB:
  - flush_active=1, pmem_write=1, wb_addr_sel=1.
  - On pmem_resp: clear the dirty bit at flush_way, then advance.
- Advance: flush_way+1. Wrap to 0 with flush_set+1.
- At SETS-1 / WAYS-1 the advance instead pulses flush_done and returns to CHECK. Counters clear.
- CPU requests during a flush are stalled (mem_resp=0) until flush_done.
- flush_req high while already flushing is ignored.
- A flush of a cache with no dirty lines takes SETS*WAYS scan cycles.
- pmem_read and pmem_write are never high together.
- All one-hot strobes have at most one bit set.

Optional Feature:
- Macro D_CACHE_PERF_CNT_EN.
- Defined:
  - hit_cnt counts every CHECK hit.
  - miss_cnt counts every CHECK miss.
  - wb_cnt counts every completed WB or FL_WB.
  - All three saturate at all-ones.
  - clr_cnt synchronously zeros them and wins over a same-cycle increment.
  - rst zeros them.
- Undefined: counters not built; hit_cnt, miss_cnt and wb_cnt tied to 0; clr_cnt ignored. The port list is unchanged.

Test Plan:
- WAYS=4. mem_read with hit_vec=0100, valid_vec=1111 -> mem_resp=1 in the same cycle, mru_way=2, lru_update=1, no pmem activity.
- mem_write, valid_vec=1111, no hit, lru_way=1, dirty_vec=0010 -> WB then FILL; way_sel=1; dirty_write=0010 with dirty_val=0 on WB resp; data_write/valid_write=0010 on FILL resp; then RESPOND with data_write=0010, dirty_val=1, mem_resp=1.
- Miss with valid_vec=1011, lru_way=0 -> victim way 2, straight to FILL, no pmem_write.
- flush_req, SETS=8, only set 3 way 1 dirty -> exactly one pmem_write burst with flush_set=3, way_sel=1; flush_done pulses once after all 32 ways are visited.
- rst asserted during FILL with pmem_read=1 -> pmem_read=0 at once; after release, state CHECK and mem_resp=0 with no request.
- With D_CACHE_PERF_CNT_EN and CNT_W=4: 16 hits -> hit_cnt stays 15; clr_cnt together with a hit -> hit_cnt=0.

Source files
------------

// File: rtl/d_cache_nway_control.sv
// N-way write-back / write-allocate data-cache controller with invalid-way
// victim preference and a full-cache flush engine.
// Optional performance counters: define D_CACHE_PERF_CNT_EN to build them.
module d_cache_nway_control #(
    parameter  int unsigned WAYS  = 4,
    parameter  int unsigned SETS  = 8,
    parameter  int unsigned CNT_W = 32,
    localparam int unsigned WAY_W = $clog2(WAYS),
    localparam int unsigned SET_W = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    output logic             mem_resp,
    input  logic [WAYS-1:0]  hit_vec,
    input  logic [WAYS-1:0]  valid_vec,
    input  logic [WAYS-1:0]  dirty_vec,
    input  logic [WAY_W-1:0] lru_way,
    output logic [WAY_W-1:0] way_sel,
    output logic [WAYS-1:0]  data_write,
    output logic [WAYS-1:0]  dirty_write,
    output logic             dirty_val,
    output logic [WAYS-1:0]  valid_write,
    output logic             lru_update,
    output logic [WAY_W-1:0] mru_way,
    output logic             load_buf,
    output logic             wb_addr_sel,
    input  logic             flush_req,
    output logic             flush_active,
    output logic [SET_W-1:0] flush_set,
    output logic             flush_done,
    input  logic             pmem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [CNT_W-1:0] wb_cnt
);

    typedef enum logic [2:0] {
        S_CHECK, S_WB, S_FILL, S_RESPOND, S_FL_SCAN, S_FL_WB
    } state_e;

    state_e           state_q, state_d;
    logic [WAY_W-1:0] victim_q, victim_d;
    logic [SET_W-1:0] flush_set_q, flush_set_d;
    logic [WAY_W-1:0] flush_way_q, flush_way_d;

    logic             req, hit, hit_found, inv_found, fl_dirty, flush_last, flush_adv;
    logic [WAYS-1:0]  hit_valid;
    logic [WAY_W-1:0] hit_way, inv_way, miss_way;

    function automatic logic [WAYS-1:0] onehot(input logic [WAY_W-1:0] w);
        logic [WAYS-1:0] r;
        r    = '0;
        r[w] = 1'b1;
        return r;
    endfunction

    assign req        = mem_read | mem_write;
    assign hit_valid  = hit_vec & valid_vec;
    assign hit        = |hit_valid;
    assign miss_way   = inv_found ? inv_way : lru_way;
    assign fl_dirty   = valid_vec[flush_way_q] & dirty_vec[flush_way_q];
    assign flush_last = (flush_set_q == SET_W'(SETS-1)) && (flush_way_q == WAY_W'(WAYS-1));
    assign flush_adv  = ((state_q == S_FL_SCAN) && !fl_dirty) ||
                        ((state_q == S_FL_WB) && pmem_resp);
    assign flush_set  = flush_set_q;

    // Lowest-index priority encoders for the hit way and the first invalid way
    always_comb begin
        hit_way   = '0;
        hit_found = 1'b0;
        inv_way   = '0;
        inv_found = 1'b0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (hit_valid[i] && !hit_found) begin
                hit_way   = WAY_W'(i);
                hit_found = 1'b1;
            end
            if (!valid_vec[i] && !inv_found) begin
                inv_way   = WAY_W'(i);
                inv_found = 1'b1;
            end
        end
    end

    // State, victim and flush-pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_CHECK;
            victim_q    <= '0;
            flush_set_q <= '0;
            flush_way_q <= '0;
        end else begin
            state_q     <= state_d;
            victim_q    <= victim_d;
            flush_set_q <= flush_set_d;
            flush_way_q <= flush_way_d;
        end
    end

    // Next-state logic, including victim capture and flush pointer walk
    always_comb begin
        state_d     = state_q;
        victim_d    = victim_q;
        flush_set_d = flush_set_q;
        flush_way_d = flush_way_q;
        case (state_q)
            S_CHECK: begin
                if (req) begin
                    if (!hit) begin
                        victim_d = miss_way;
                        state_d  = (valid_vec[miss_way] && dirty_vec[miss_way]) ? S_WB : S_FILL;
                    end
                end else if (flush_req) begin
                    state_d     = S_FL_SCAN;
                    flush_set_d = '0;
                    flush_way_d = '0;
                end
            end
            S_WB:      if (pmem_resp) state_d = S_FILL;
            S_FILL:    if (pmem_resp) state_d = S_RESPOND;
            S_RESPOND: state_d = S_CHECK;
            S_FL_SCAN: if (fl_dirty) state_d = S_FL_WB;
            default:   ;
        endcase
        // Advance shared by FL_SCAN (clean way) and FL_WB (writeback done)
        if (flush_adv) begin
            state_d = S_FL_SCAN;
            if (flush_last) begin
                state_d     = S_CHECK;
                flush_set_d = '0;
                flush_way_d = '0;
            end else if (flush_way_q == WAY_W'(WAYS-1)) begin
                flush_way_d = '0;
                flush_set_d = flush_set_q + SET_W'(1);
            end else begin
                flush_way_d = flush_way_q + WAY_W'(1);
            end
        end
    end

    // Datapath strobes; everything forced low while rst is asserted
    always_comb begin
        mem_resp     = 1'b0;
        way_sel      = '0;
        data_write   = '0;
        dirty_write  = '0;
        dirty_val    = 1'b0;
        valid_write  = '0;
        lru_update   = 1'b0;
        mru_way      = '0;
        load_buf     = 1'b0;
        wb_addr_sel  = 1'b0;
        flush_active = 1'b0;
        flush_done   = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        if (!rst) begin
            case (state_q)
                S_CHECK: begin
                    if (req && hit) begin
                        mem_resp   = 1'b1;
                        lru_update = 1'b1;
                        mru_way    = hit_way;
                        way_sel    = hit_way;
                        if (mem_write) begin
                            data_write  = onehot(hit_way);
                            dirty_write = onehot(hit_way);
                            dirty_val   = 1'b1;
                        end
                    end
                end
                S_WB: begin
                    pmem_write  = 1'b1;
                    wb_addr_sel = 1'b1;
                    way_sel     = victim_q;
                    if (pmem_resp) dirty_write = onehot(victim_q);
                end
                S_FILL: begin
                    pmem_read = 1'b1;
                    load_buf  = 1'b1;
                    way_sel   = victim_q;
                    if (pmem_resp) begin
                        data_write  = onehot(victim_q);
                        valid_write = onehot(victim_q);
                    end
                end
                S_RESPOND: begin
                    mem_resp   = 1'b1;
                    lru_update = 1'b1;
                    mru_way    = victim_q;
                    way_sel    = victim_q;
                    if (mem_write) begin
                        data_write  = onehot(victim_q);
                        dirty_write = onehot(victim_q);
                        dirty_val   = 1'b1;
                    end
                end
                S_FL_SCAN: begin
                    flush_active = 1'b1;
                    way_sel      = flush_way_q;
                end
                S_FL_WB: begin
                    flush_active = 1'b1;
                    pmem_write   = 1'b1;
                    wb_addr_sel  = 1'b1;
                    way_sel      = flush_way_q;
                    if (pmem_resp) dirty_write = onehot(flush_way_q);
                end
                default: ;
            endcase
            flush_done = flush_adv && flush_last;
        end
    end

`ifdef D_CACHE_PERF_CNT_EN
    logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;
    logic             hit_ev, miss_ev, wb_ev;

    assign hit_ev  = (state_q == S_CHECK) && req && hit;
    assign miss_ev = (state_q == S_CHECK) && req && !hit;
    assign wb_ev   = ((state_q == S_WB) || (state_q == S_FL_WB)) && pmem_resp;

    // Saturating event counters; clear beats a same-cycle increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst || clr_cnt) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            if (hit_ev  && (hit_cnt_q  != '1)) hit_cnt_q  <= hit_cnt_q  + CNT_W'(1);
            if (miss_ev && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
            if (wb_ev   && (wb_cnt_q   != '1)) wb_cnt_q   <= wb_cnt_q   + CNT_W'(1);
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
    assign wb_cnt   = wb_cnt_q;
`else
    logic unused_clr_cnt;
    assign unused_clr_cnt = clr_cnt;
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
    assign wb_cnt   = '0;
`endif

endmodule

// File: tb/tb_d_cache_nway_control.sv
// Randomized self-checking bench for d_cache_nway_control. The bench plays the
// cache datapath: it holds per-set valid/dirty arrays and derives every expected
// strobe from the controller's transaction-level rules.
module tb_d_cache_nway_control;

    localparam int WAYS  = 4;
    localparam int SETS  = 8;
    localparam int WAY_W = $clog2(WAYS);
    localparam int SET_W = $clog2(SETS);
`ifdef D_CACHE_PERF_CNT_EN
    localparam int  TB_CNT_W = 4;
    localparam bit  PERF     = 1'b1;
`else
    localparam int  TB_CNT_W = 32;
    localparam bit  PERF     = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                mem_read, mem_write, mem_resp;
    logic [WAYS-1:0]     hit_vec, valid_vec, dirty_vec;
    logic [WAY_W-1:0]    lru_way, way_sel, mru_way;
    logic [WAYS-1:0]     data_write, dirty_write, valid_write;
    logic                dirty_val, lru_update, load_buf, wb_addr_sel;
    logic                flush_req, flush_active, flush_done;
    logic [SET_W-1:0]    flush_set;
    logic                pmem_resp, pmem_read, pmem_write, clr_cnt;
    logic [TB_CNT_W-1:0] hit_cnt, miss_cnt, wb_cnt;

    d_cache_nway_control #(.WAYS(WAYS), .SETS(SETS), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec),
        .lru_way(lru_way), .way_sel(way_sel),
        .data_write(data_write), .dirty_write(dirty_write), .dirty_val(dirty_val),
        .valid_write(valid_write), .lru_update(lru_update), .mru_way(mru_way),
        .load_buf(load_buf), .wb_addr_sel(wb_addr_sel),
        .flush_req(flush_req), .flush_active(flush_active), .flush_set(flush_set),
        .flush_done(flush_done),
        .pmem_resp(pmem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .clr_cnt(clr_cnt), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
    );

    always #5 clk = ~clk;

    // Datapath model and expected counters
    logic [WAYS-1:0]     m_valid [SETS];
    logic [WAYS-1:0]     m_dirty [SETS];
    logic [TB_CNT_W-1:0] e_hit, e_miss, e_wb;
    int                  n_cmp = 0;
    int                  n_mis = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lowest_set(input logic [WAYS-1:0] v);
        for (int i = 0; i < WAYS; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [WAYS-1:0] oh(input int w);
        logic [WAYS-1:0] r;
        r    = '0;
        r[w] = 1'b1;
        return r;
    endfunction

    function automatic logic [TB_CNT_W-1:0] sat_inc(input logic [TB_CNT_W-1:0] x);
        return (x == '1) ? x : x + TB_CNT_W'(1);
    endfunction

    task automatic settle(); #2; endtask
    task automatic tick();   @(posedge clk); #1; endtask

    task automatic check_counters();
        check_eq("hit_cnt",  hit_cnt,  PERF ? e_hit  : '0);
        check_eq("miss_cnt", miss_cnt, PERF ? e_miss : '0);
        check_eq("wb_cnt",   wb_cnt,   PERF ? e_wb   : '0);
    endtask

    task automatic clear_model_counters();
        e_hit = '0; e_miss = '0; e_wb = '0;
    endtask

    // One CPU access from CHECK through completion, with random pmem latency
    task automatic do_access(input bit wr, input int s, input logic [WAYS-1:0] hv,
                             input logic [WAY_W-1:0] lru, input bit clr);
        logic [WAYS-1:0] hitv;
        int              hw, vic, lat;
        bit              do_wb;
        mem_read  = !wr;   mem_write = wr;
        hit_vec   = hv;    lru_way   = lru;
        valid_vec = m_valid[s]; dirty_vec = m_dirty[s];
        flush_req = ($urandom_range(0, 3) == 0);
        clr_cnt   = clr;   pmem_resp = 1'b0;
        settle();
        hitv = hv & m_valid[s];
        check_eq("pmem_idle_rd", pmem_read, 1'b0);
        check_eq("pmem_idle_wr", pmem_write, 1'b0);
        if (hitv != '0) begin
            hw = lowest_set(hitv);
            check_eq("hit_resp", mem_resp, 1'b1);
            check_eq("hit_lru", lru_update, 1'b1);
            check_eq("hit_mru", mru_way, hw);
            check_eq("hit_waysel", way_sel, hw);
            check_eq("hit_dwrite", data_write, wr ? oh(hw) : '0);
            check_eq("hit_dirtyw", dirty_write, wr ? oh(hw) : '0);
            if (wr) begin
                check_eq("hit_dirtyval", dirty_val, 1'b1);
                m_dirty[s][hw] = 1'b1;
            end
            e_hit = sat_inc(e_hit);
            if (clr) clear_model_counters();
            tick();
        end else begin
            vic   = lowest_set(~m_valid[s]);
            if (vic < 0) vic = int'(lru);
            do_wb = m_valid[s][vic] && m_dirty[s][vic];
            check_eq("miss_resp", mem_resp, 1'b0);
            e_miss = sat_inc(e_miss);
            if (clr) clear_model_counters();
            tick();
            flush_req = 1'b0; clr_cnt = 1'b0;
            if (do_wb) begin
                lat = $urandom_range(0, 3);
                repeat (lat) begin
                    settle();
                    check_eq("wb_pwrite", pmem_write, 1'b1);
                    check_eq("wb_pread", pmem_read, 1'b0);
                    check_eq("wb_addrsel", wb_addr_sel, 1'b1);
                    check_eq("wb_waysel", way_sel, vic);
                    check_eq("wb_dirtyw_wait", dirty_write, '0);
                    check_eq("wb_resp", mem_resp, 1'b0);
                    tick();
                end
                pmem_resp = 1'b1;
                settle();
                check_eq("wb_pwrite_end", pmem_write, 1'b1);
                check_eq("wb_dirtyw", dirty_write, oh(vic));
                check_eq("wb_dirtyval", dirty_val, 1'b0);
                m_dirty[s][vic] = 1'b0;
                e_wb = sat_inc(e_wb);
                tick();
                pmem_resp = 1'b0;
                dirty_vec = m_dirty[s];
            end
            lat = $urandom_range(0, 3);
            repeat (lat) begin
                settle();
                check_eq("fill_pread", pmem_read, 1'b1);
                check_eq("fill_pwrite", pmem_write, 1'b0);
                check_eq("fill_loadbuf", load_buf, 1'b1);
                check_eq("fill_dwrite_wait", data_write, '0);
                check_eq("fill_vwrite_wait", valid_write, '0);
                tick();
            end
            pmem_resp = 1'b1;
            settle();
            check_eq("fill_pread_end", pmem_read, 1'b1);
            check_eq("fill_dwrite", data_write, oh(vic));
            check_eq("fill_vwrite", valid_write, oh(vic));
            m_valid[s][vic] = 1'b1;
            tick();
            pmem_resp = 1'b0;
            valid_vec = m_valid[s];
            settle();
            check_eq("rsp_resp", mem_resp, 1'b1);
            check_eq("rsp_lru", lru_update, 1'b1);
            check_eq("rsp_mru", mru_way, vic);
            check_eq("rsp_pread", pmem_read, 1'b0);
            check_eq("rsp_dwrite", data_write, wr ? oh(vic) : '0);
            if (wr) begin
                check_eq("rsp_dirtyval", dirty_val, 1'b1);
                m_dirty[s][vic] = 1'b1;
            end
            tick();
        end
        mem_read = 1'b0; mem_write = 1'b0; flush_req = 1'b0; clr_cnt = 1'b0;
        settle();
        check_eq("idle_resp", mem_resp, 1'b0);
        check_eq("idle_flushact", flush_active, 1'b0);
        check_counters();
    endtask

    // Full flush walk; optionally hammers the CPU port to confirm stalling
    task automatic do_flush(input bit stall);
        bit last;
        int lat;
        mem_read = 1'b0; mem_write = 1'b0; flush_req = 1'b1; pmem_resp = 1'b0;
        settle();
        check_eq("fl_start_act", flush_active, 1'b0);
        tick();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                last      = (s == SETS-1) && (w == WAYS-1);
                valid_vec = m_valid[s]; dirty_vec = m_dirty[s];
                mem_read  = stall ? 1'($urandom_range(0, 1)) : 1'b0;
                hit_vec   = WAYS'($urandom);
                flush_req = 1'($urandom_range(0, 1));
                settle();
                check_eq("fl_active", flush_active, 1'b1);
                check_eq("fl_set", flush_set, s);
                check_eq("fl_waysel", way_sel, w);
                check_eq("fl_stall", mem_resp, 1'b0);
                check_eq("fl_pread", pmem_read, 1'b0);
                if (m_valid[s][w] && m_dirty[s][w]) begin
                    check_eq("fl_scan_done", flush_done, 1'b0);
                    check_eq("fl_scan_pwrite", pmem_write, 1'b0);
                    tick();
                    lat = $urandom_range(0, 3);
                    repeat (lat) begin
                        settle();
                        check_eq("flwb_pwrite", pmem_write, 1'b1);
                        check_eq("flwb_addrsel", wb_addr_sel, 1'b1);
                        check_eq("flwb_set", flush_set, s);
                        check_eq("flwb_dirtyw_wait", dirty_write, '0);
                        tick();
                    end
                    pmem_resp = 1'b1;
                    settle();
                    check_eq("flwb_pwrite_end", pmem_write, 1'b1);
                    check_eq("flwb_waysel", way_sel, w);
                    check_eq("flwb_dirtyw", dirty_write, oh(w));
                    check_eq("flwb_dirtyval", dirty_val, 1'b0);
                    check_eq("flwb_done", flush_done, last);
                    m_dirty[s][w] = 1'b0;
                    e_wb = sat_inc(e_wb);
                    tick();
                    pmem_resp = 1'b0;
                end else begin
                    check_eq("fl_done", flush_done, last);
                    check_eq("fl_pwrite", pmem_write, 1'b0);
                    tick();
                end
            end
        end
        mem_read = 1'b0; flush_req = 1'b0;
        settle();
        check_eq("fl_end_act", flush_active, 1'b0);
        check_eq("fl_end_done", flush_done, 1'b0);
        check_counters();
    endtask

    initial begin
        bit              wr;
        int              s;
        logic [WAYS-1:0] hv;

        for (int i = 0; i < SETS; i++) begin
            m_valid[i] = '0; m_dirty[i] = '0;
        end
        clear_model_counters();
        rst = 1'b1; mem_read = 1'b1; mem_write = 1'b0; hit_vec = '1; valid_vec = '1;
        dirty_vec = '0; lru_way = '0; flush_req = 1'b0; pmem_resp = 1'b0; clr_cnt = 1'b0;
        tick(); tick();
        settle();
        check_eq("rst_resp", mem_resp, 1'b0);
        check_eq("rst_lru", lru_update, 1'b0);
        check_eq("rst_pread", pmem_read, 1'b0);
        check_eq("rst_pwrite", pmem_write, 1'b0);
        check_eq("rst_flushact", flush_active, 1'b0);
        check_eq("rst_flushset", flush_set, 0);
        check_counters();
        mem_read = 1'b0;
        rst = 1'b0;
        tick();

        // Read hit: way 2 of a fully valid set
        m_valid[0] = 4'b1111;
        do_access(1'b0, 0, 4'b0100, 2'd0, 1'b0);
        // Write miss on a full set, LRU victim dirty: writeback then fill
        m_valid[1] = 4'b1111; m_dirty[1] = 4'b0010;
        do_access(1'b1, 1, 4'b0000, 2'd1, 1'b0);
        // Miss with an invalid way present: that way wins over LRU
        m_valid[2] = 4'b1011; m_dirty[2] = 4'b1011;
        do_access(1'b0, 2, 4'b0000, 2'd0, 1'b0);

        // Reset during FILL drops pmem_read immediately
        m_valid[4] = 4'b1111; m_dirty[4] = 4'b0000;
        mem_read = 1'b1; hit_vec = '0; valid_vec = m_valid[4]; dirty_vec = m_dirty[4];
        lru_way = 2'd3;
        tick();
        settle();
        check_eq("rstfill_pread_pre", pmem_read, 1'b1);
        #1 rst = 1'b1;
        #1;
        check_eq("rstfill_pread", pmem_read, 1'b0);
        check_eq("rstfill_loadbuf", load_buf, 1'b0);
        clear_model_counters();
        tick();
        check_counters();
        mem_read = 1'b0; rst = 1'b0;
        settle();
        check_eq("rstrel_resp", mem_resp, 1'b0);
        check_eq("rstrel_pread", pmem_read, 1'b0);
        check_eq("rstrel_flushact", flush_active, 1'b0);
        tick();

        // Randomized traffic with a stalled-CPU flush in the middle
        for (int n = 0; n < 160; n++) begin
            s  = $urandom_range(0, SETS-1);
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) != 0) hv = WAYS'($urandom);
            else                           hv = WAYS'($urandom) & ~m_valid[s];
            do_access(wr, s, hv, WAY_W'($urandom_range(0, WAYS-1)), $urandom_range(0, 15) == 0);
            if (n == 80) do_flush(1'b1);
        end
        do_flush(1'b0);

        // Single dirty line: set 3 way 1
        for (int i = 0; i < SETS; i++) begin
            m_valid[i] = 4'b1111; m_dirty[i] = '0;
        end
        m_dirty[3] = 4'b0010;
        do_flush(1'b0);

        // Counter clear with a hit, saturation, then clear again with a hit
        do_access(1'b0, 0, 4'b0001, 2'd0, 1'b1);
        repeat (16) do_access(1'b0, 0, 4'b0001, 2'd0, 1'b0);
        do_access(1'b0, 0, 4'b0001, 2'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
